// File: rtl/chatbot_soc_onchip_ram_dp_pkg.sv
// Shared constants and helpers for the chatbot SoC on-chip memories.
package chatbot_mem_pkg;

  localparam int MAX_READ_LATENCY = 3;
  localparam int DEFAULT_DATA_W   = 32;

  // Smallest n with 2**n >= depth; an address bus narrower than this cannot reach every word.
  function automatic int clog2_depth(input int depth);
    int n;
    n = 0;
    while ((1 << n) < depth) n++;
    return n;
  endfunction

endpackage

// File: rtl/chatbot_soc_onchip_ram_dp_if.sv
// Bus bundle for the dual-port RAM: port A is the CPU read/write slave,
// port B the read-only classifier port. clk/reset/clken stay outside.
interface chatbot_soc_onchip_ram_dp_if #(
  parameter int DATA_W = chatbot_mem_pkg::DEFAULT_DATA_W,
  parameter int ADDR_W = 8
);
  logic                a_chipselect;
  logic [ADDR_W-1:0]   a_address;
  logic                a_read;
  logic                a_write;
  logic [DATA_W/8-1:0] a_byteenable;
  logic [DATA_W-1:0]   a_writedata;
  logic [DATA_W-1:0]   a_readdata;
  logic                a_readdatavalid;
  logic [ADDR_W-1:0]   b_address;
  logic                b_read;
  logic [DATA_W-1:0]   b_readdata;
  logic                b_readdatavalid;

  modport master (
    output a_chipselect, a_address, a_read, a_write, a_byteenable, a_writedata,
           b_address, b_read,
    input  a_readdata, a_readdatavalid, b_readdata, b_readdatavalid
  );

  modport slave (
    input  a_chipselect, a_address, a_read, a_write, a_byteenable, a_writedata,
           b_address, b_read,
    output a_readdata, a_readdatavalid, b_readdata, b_readdatavalid
  );
endinterface

// File: rtl/chatbot_soc_ram_rd_pipe.sv
// Read-return pipeline for one RAM port. Stage 1 data is the RAM output
// register (raw_i) held in the parent; later stages are carried here.
// Data and the out-of-range flag only advance behind a valid bit, so the
// final stage keeps the last returned word between responses.
module chatbot_soc_ram_rd_pipe #(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic              acc_i,
  input  logic              oor_i,
  input  logic [DATA_W-1:0] raw_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o
);

  typedef struct packed {
    logic              valid;
    logic              oor;
    logic [DATA_W-1:0] data;
  } rd_stage_t;

  // oor=1 at reset makes the output read as zero until the first response.
  localparam rd_stage_t STG_RST = '{valid: 1'b0, oor: 1'b1, data: '0};

  rd_stage_t [READ_LATENCY:1] stg_q, stg_d, stg_v;

  // View of the pipeline with stage-1 data taken from the RAM output register.
  always_comb begin
    stg_v         = stg_q;
    stg_v[1].data = raw_i;
  end

  // Next state: valid bits shift every enabled cycle, payload only follows a valid.
  always_comb begin
    stg_d = stg_q;
    if (clken) begin
      stg_d[1].valid = acc_i;
      if (acc_i) stg_d[1].oor = oor_i;
      for (int k = 2; k <= READ_LATENCY; k++) begin
        stg_d[k].valid = stg_v[k-1].valid;
        if (stg_v[k-1].valid) begin
          stg_d[k].oor  = stg_v[k-1].oor;
          stg_d[k].data = stg_v[k-1].data;
        end
      end
    end
  end

  // Pipeline registers; reset discards every read in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= READ_LATENCY; k++) stg_q[k] <= STG_RST;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign rvalid_o = stg_q[READ_LATENCY].valid;
  assign rdata_o  = stg_v[READ_LATENCY].oor ? '0 : stg_v[READ_LATENCY].data;

endmodule

// File: rtl/chatbot_soc_onchip_ram_dp.sv
// Dual-port on-chip RAM: port A CPU read/write with byte enables, port B
// read-only. Both reads are registered straight off the array so the
// storage maps onto true dual-port block RAM; latency is added behind it.
module chatbot_soc_onchip_ram_dp
  import chatbot_mem_pkg::*;
#(
  parameter int    DATA_W       = DEFAULT_DATA_W,
  parameter int    DEPTH        = 256,
  parameter int    ADDR_W       = 8,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "chatbot_soc_onchip_ram_dp.hex"
) (
  input logic                        clk,
  input logic                        reset_n,
  input logic                        clken,
  chatbot_soc_onchip_ram_dp_if.slave bus
);

  localparam int IDX_W     = (clog2_depth(DEPTH) > 0) ? clog2_depth(DEPTH) : 1;
  localparam int ADDR_SPAN = 1 << ADDR_W;

  if (DATA_W % 8 != 0) begin : g_chk_data_w
    $error("DATA_W (%0d) must be a multiple of 8", DATA_W);
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_chk_lat
    $error("READ_LATENCY (%0d) must be 1..%0d", READ_LATENCY, MAX_READ_LATENCY);
  end
  if (ADDR_W < clog2_depth(DEPTH)) begin : g_chk_addr_w
    $error("ADDR_W (%0d) too narrow for DEPTH (%0d)", ADDR_W, DEPTH);
  end

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] a_raw_q, b_raw_q;
  logic              a_oor, b_oor;
  logic              a_wr_ok, a_rd_acc, b_rd_acc;
  logic [IDX_W-1:0]  a_idx, b_idx;

  // Only a partially populated address space can go out of range.
  if (DEPTH < ADDR_SPAN) begin : g_oor
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    assign a_oor = bus.a_address > LAST;
    assign b_oor = bus.b_address > LAST;
  end else begin : g_no_oor
    assign a_oor = 1'b0;
    assign b_oor = 1'b0;
  end

  // A read colliding with a write is dropped; out-of-range indices are clamped
  // so the array is never indexed past its end (the pipe zeroes the data).
  always_comb begin
    a_wr_ok  = bus.a_chipselect & bus.a_write & ~a_oor;
    a_rd_acc = bus.a_chipselect & bus.a_read & ~bus.a_write;
    b_rd_acc = bus.b_read;
    a_idx    = a_oor ? '0 : bus.a_address[IDX_W-1:0];
    b_idx    = b_oor ? '0 : bus.b_address[IDX_W-1:0];
  end

  // Port A: byte-lane writes plus registered read of the array.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (a_wr_ok) begin
        for (int i = 0; i < DATA_W/8; i++)
          if (bus.a_byteenable[i]) mem[a_idx][8*i +: 8] <= bus.a_writedata[8*i +: 8];
      end
      if (a_rd_acc) a_raw_q <= mem[a_idx];
    end
  end

  // Port B: registered read; a same-cycle port A write is seen as old data.
  always_ff @(posedge clk) begin
    if (clken && b_rd_acc) b_raw_q <= mem[b_idx];
  end

  chatbot_soc_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)) u_pipe_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .clken    (clken),
    .acc_i    (a_rd_acc),
    .oor_i    (a_oor),
    .raw_i    (a_raw_q),
    .rdata_o  (bus.a_readdata),
    .rvalid_o (bus.a_readdatavalid)
  );

  chatbot_soc_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)) u_pipe_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .clken    (clken),
    .acc_i    (b_rd_acc),
    .oor_i    (b_oor),
    .raw_i    (b_raw_q),
    .rdata_o  (bus.b_readdata),
    .rvalid_o (bus.b_readdatavalid)
  );

endmodule

// File: tb/tb_chatbot_soc_onchip_ram_dp.sv
// Scoreboard bench: stimulus pushes expected responses (value and the enabled
// cycle they are due on) from a word-array model; a negedge monitor pops them.
module tb_chatbot_soc_onchip_ram_dp;
  localparam int DW = 32, DEPTH = 200, AW = 8, L = 2;

  logic clk = 1'b0, reset_n = 1'b1, clken = 1'b1;
  always #5 clk = ~clk;

  chatbot_soc_onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  chatbot_soc_onchip_ram_dp #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(L), .INIT_FILE("")
  ) dut (.clk(clk), .reset_n(reset_n), .clken(clken), .bus(bus));

  typedef struct { logic [DW-1:0] d; int due; } exp_t;
  exp_t          qa[$], qb[$];
  logic [DW-1:0] model [0:DEPTH-1];
  logic [DW-1:0] last_a = '0, last_b = '0;
  int            encnt = 0, n_tests = 0, n_fail = 0;

  // Count enabled clock edges; a read accepted at enabled edge n is due at n+L-1.
  always @(posedge clk) if (reset_n && clken) encnt++;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) ? model[a] : '0;
  endfunction

  // One bus cycle; called just after a rising edge, returns just after the next.
  task automatic drive(input bit ce, input bit acs, input bit ard, input bit awr,
                       input logic [AW-1:0] aad, input logic [3:0] be, input logic [DW-1:0] wd,
                       input bit brd, input logic [AW-1:0] bad);
    exp_t e;
    clken = ce;
    bus.a_chipselect = acs; bus.a_read = ard; bus.a_write = awr;
    bus.a_address = aad; bus.a_byteenable = be; bus.a_writedata = wd;
    bus.b_read = brd; bus.b_address = bad;
    if (ce) begin
      if (brd) begin e.d = m_rd(bad); e.due = encnt + L; qb.push_back(e); end
      if (acs && ard && !awr) begin e.d = m_rd(aad); e.due = encnt + L; qa.push_back(e); end
      if (acs && awr && int'(aad) < DEPTH)
        for (int i = 0; i < 4; i++) if (be[i]) model[aad][8*i +: 8] = wd[8*i +: 8];
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, '0, '0, '0, 0, '0);
  endtask
  task automatic rd_a(input logic [AW-1:0] a);
    drive(1, 1, 1, 0, a, '0, '0, 0, '0);
  endtask
  task automatic wr_a(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
    drive(1, 1, 0, 1, a, be, d, 0, '0);
  endtask

  task automatic mon(input bit pb, input logic v, input logic [DW-1:0] d);
    exp_t e; bit have; string nm;
    nm = pb ? "b" : "a";
    have = 0;
    if (!pb && qa.size() > 0) begin e = qa[0]; have = 1; end
    if (pb && qb.size() > 0) begin e = qb[0]; have = 1; end
    if (v === 1'b1) begin
      // A held valid during a stall is consumed on the next enabled cycle.
      if (clken) begin
        if (!have) chk({nm, "_spurious_valid"}, {31'b0, v}, '0);
        else begin
          if (pb) qb.delete(0); else qa.delete(0);
          chk({nm, "_data"}, d, e.d);
          chk({nm, "_latency"}, 32'(encnt), 32'(e.due));
          if (pb) last_b = e.d; else last_a = e.d;
        end
      end
    end else begin
      chk({nm, "_hold"}, d, pb ? last_b : last_a);
      if (clken && have && encnt >= e.due) begin
        chk({nm, "_missing_valid"}, {31'b0, v}, 32'd1);
        if (pb) qb.delete(0); else qa.delete(0);
      end
    end
  endtask

  // Monitor: reset values while in reset, otherwise scoreboard both ports.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_a_valid", {31'b0, bus.a_readdatavalid}, '0);
      chk("rst_a_data", bus.a_readdata, '0);
      chk("rst_b_valid", {31'b0, bus.b_readdatavalid}, '0);
      chk("rst_b_data", bus.b_readdata, '0);
      qa.delete(); qb.delete();
      last_a = '0; last_b = '0;
    end else begin
      mon(0, bus.a_readdatavalid, bus.a_readdata);
      mon(1, bus.b_readdatavalid, bus.b_readdata);
    end
  end

  initial begin
    bus.a_chipselect = 0; bus.a_read = 0; bus.a_write = 0; bus.a_address = '0;
    bus.a_byteenable = '0; bus.a_writedata = '0; bus.b_read = 0; bus.b_address = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Preload every word (no image file in this bench).
    for (int a = 0; a < DEPTH; a++)
      wr_a(8'(a), 4'hF, (a == 3) ? 32'hCAFE_F00D : (a == 10) ? 32'h1122_3344 : $urandom);
    idle(1);

    // Init word and latency.
    rd_a(8'd3); idle(3);

    // Byte enables, then an all-zero enable.
    wr_a(8'd10, 4'b0101, 32'hAABB_CCDD); rd_a(8'd10);
    wr_a(8'd10, 4'b0000, 32'h0BAD_0BAD); rd_a(8'd10); idle(3);

    // Read-during-write: B same cycle sees old, next cycle A and B see new.
    drive(1, 1, 0, 1, 8'd7, 4'hF, 32'h5, 1, 8'd7);
    drive(1, 1, 1, 0, 8'd7, '0, '0, 1, 8'd7);
    idle(3);

    // Stall mid-stream; requests during clken=0 must be ignored.
    rd_a(8'd3); rd_a(8'd10);
    drive(0, 1, 1, 0, 8'd7, '0, '0, 1, 8'd7);
    drive(0, 1, 1, 0, 8'd7, '0, '0, 1, 8'd7);
    rd_a(8'd7); idle(4);

    // Reset with two reads in flight; memory must survive.
    drive(1, 1, 1, 0, 8'd3, '0, '0, 1, 8'd10);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(4); rd_a(8'd3); idle(3);

    // Boundary addresses.
    wr_a(8'd200, 4'hF, 32'hDEAD_BEEF);
    rd_a(8'd200); rd_a(8'd255); rd_a(8'd199);
    drive(1, 0, 0, 0, '0, '0, '0, 1, 8'd0);
    idle(3);

    // Random traffic on both ports.
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [AW-1:0] aa, ba;
      op = $urandom_range(0, 3);
      aa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      ba = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, op[0], op[1], aa,
            4'($urandom), $urandom, $urandom_range(0, 1) == 1, ba);
    end

    idle(L + 3);
    chk("a_queue_drained", 32'(qa.size()), '0);
    chk("b_queue_drained", 32'(qb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
